// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: backend redirect, branch prediction, I-cache request/response
// and the push port into the instruction buffer, seen from the fetch unit (master).
interface fetch_pc_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        bpu_taken;
  logic [31:0] bpu_target;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;

  logic        buffer_stall;
  logic        inst_valid;
  logic [31:0] pc1;
  logic [31:0] pc2;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic [31:0] pred_addr;
  logic        pc_is_exception_out1;
  logic        pc_is_exception_out2;
  logic [6:0]  pc_exception_cause_out1;
  logic [6:0]  pc_exception_cause_out2;

  modport master (
    input  flush, redirect_pc, bpu_taken, bpu_target,
    input  inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2,
    input  buffer_stall,
    output inst_req, inst_addr,
    output inst_valid, pc1, pc2, inst1, inst2, pred_addr,
    output pc_is_exception_out1, pc_is_exception_out2,
    output pc_exception_cause_out1, pc_exception_cause_out2
  );

  modport slave (
    output flush, redirect_pc, bpu_taken, bpu_target,
    output inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2,
    output buffer_stall,
    input  inst_req, inst_addr,
    input  inst_valid, pc1, pc2, inst1, inst2, pred_addr,
    input  pc_is_exception_out1, pc_is_exception_out2,
    input  pc_exception_cause_out1, pc_exception_cause_out2
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: one outstanding two-word I-cache fetch at a time, registered push
// of each group (with predicted next PC) into the instruction buffer.
//   state    | meaning
//   S_REQ    | requesting at pc (or, if pc misaligned, emitting an ADEF group)
//   S_WAIT   | request accepted, waiting for read data
//   S_HOLD   | data captured, buffer stalled
//   S_CANCEL | flushed transaction still in flight, its data will be dropped
//   S_HALT   | ADEF group emitted, idle until the next flush
module fetch_pc_unit (
  input  logic        clk,
  input  logic        rst,
  fetch_pc_if.master  bus
);
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [6:0]  EXC_ADEF = 7'h08;
  localparam logic [31:0] NOP_INST = 32'h03400000;

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_CANCEL = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] next_pc_q;
  logic [31:0] hold1_q;
  logic [31:0] hold2_q;

  logic        valid_q;
  logic [31:0] pc1_q;
  logic [31:0] pc2_q;
  logic [31:0] inst1_q;
  logic [31:0] inst2_q;
  logic [31:0] pred_q;
  logic        exc1_q;
  logic        exc2_q;
  logic [6:0]  cause1_q;
  logic [6:0]  cause2_q;

  logic        pc_aligned;
  logic        req;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign req        = (state_q == S_REQ) && pc_aligned;

  assign bus.inst_req                = req;
  assign bus.inst_addr               = pc_q;
  assign bus.inst_valid              = valid_q & ~bus.flush;
  assign bus.pc1                     = pc1_q;
  assign bus.pc2                     = pc2_q;
  assign bus.inst1                   = inst1_q;
  assign bus.inst2                   = inst2_q;
  assign bus.pred_addr               = pred_q;
  assign bus.pc_is_exception_out1    = exc1_q;
  assign bus.pc_is_exception_out2    = exc2_q;
  assign bus.pc_exception_cause_out1 = cause1_q;
  assign bus.pc_exception_cause_out2 = cause2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      next_pc_q <= 32'h0;
      hold1_q   <= 32'h0;
      hold2_q   <= 32'h0;
      valid_q   <= 1'b0;
      pc1_q     <= 32'h0;
      pc2_q     <= 32'h0;
      inst1_q   <= 32'h0;
      inst2_q   <= 32'h0;
      pred_q    <= 32'h0;
      exc1_q    <= 1'b0;
      exc2_q    <= 1'b0;
      cause1_q  <= 7'h0;
      cause2_q  <= 7'h0;
    end else begin
      valid_q <= 1'b0;
      if (bus.flush) begin
        pc_q <= bus.redirect_pc;
        unique case (state_q)
          S_REQ:    state_q <= (req && bus.inst_addr_ok) ? S_CANCEL : S_REQ;
          S_WAIT:   state_q <= bus.inst_data_ok ? S_REQ : S_CANCEL;
          // A response arriving alongside the redirect retires the cancelled fetch.
          S_CANCEL: state_q <= bus.inst_data_ok ? S_REQ : S_CANCEL;
          default:  state_q <= S_REQ;
        endcase
      end else begin
        unique case (state_q)
          S_REQ: begin
            if (pc_aligned) begin
              if (bus.inst_addr_ok) begin
                next_pc_q <= bus.bpu_taken ? bus.bpu_target : pc_q + 32'd8;
                state_q   <= S_WAIT;
              end
            end else if (!bus.buffer_stall) begin
              valid_q  <= 1'b1;
              pc1_q    <= pc_q;
              pc2_q    <= pc_q + 32'd4;
              inst1_q  <= NOP_INST;
              inst2_q  <= NOP_INST;
              pred_q   <= pc_q + 32'd8;
              exc1_q   <= 1'b1;
              exc2_q   <= 1'b1;
              cause1_q <= EXC_ADEF;
              cause2_q <= EXC_ADEF;
              state_q  <= S_HALT;
            end
          end
          S_WAIT: begin
            if (bus.inst_data_ok) begin
              if (!bus.buffer_stall) begin
                valid_q  <= 1'b1;
                pc1_q    <= pc_q;
                pc2_q    <= pc_q + 32'd4;
                inst1_q  <= bus.inst_rdata1;
                inst2_q  <= bus.inst_rdata2;
                pred_q   <= next_pc_q;
                exc1_q   <= 1'b0;
                exc2_q   <= 1'b0;
                cause1_q <= 7'h0;
                cause2_q <= 7'h0;
                pc_q     <= next_pc_q;
                state_q  <= S_REQ;
              end else begin
                hold1_q <= bus.inst_rdata1;
                hold2_q <= bus.inst_rdata2;
                state_q <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus.buffer_stall) begin
              valid_q  <= 1'b1;
              pc1_q    <= pc_q;
              pc2_q    <= pc_q + 32'd4;
              inst1_q  <= hold1_q;
              inst2_q  <= hold2_q;
              pred_q   <= next_pc_q;
              exc1_q   <= 1'b0;
              exc2_q   <= 1'b0;
              cause1_q <= 7'h0;
              cause2_q <= 7'h0;
              pc_q     <= next_pc_q;
              state_q  <= S_REQ;
            end
          end
          S_CANCEL: begin
            if (bus.inst_data_ok) state_q <= S_REQ;
          end
          S_HALT: state_q <= S_HALT;
          default: state_q <= S_REQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_if bus();
  fetch_pc_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags describing what is outstanding, plus the buffer-side outputs.
  logic [31:0] m_pc, m_next, m_h1, m_h2;
  logic        m_busy, m_drop, m_held, m_halt;
  logic        m_valid, m_x;
  logic [31:0] m_pc1, m_pc2, m_i1, m_i2, m_pred;
  logic [6:0]  m_c;

  function automatic logic m_req();
    return !m_busy && !m_drop && !m_held && !m_halt && (m_pc[1:0] == 2'b00);
  endfunction

  task automatic m_push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] nxt,
                        input logic x);
    m_valid = 1'b1;
    m_pc1   = m_pc;
    m_pc2   = m_pc + 32'd4;
    m_i1    = a;
    m_i2    = b;
    m_pred  = nxt;
    m_x     = x;
    m_c     = x ? 7'h08 : 7'h00;
  endtask

  task automatic model_reset();
    m_pc = 32'h1c000000; m_next = 0; m_h1 = 0; m_h2 = 0;
    m_busy = 0; m_drop = 0; m_held = 0; m_halt = 0;
    m_valid = 0; m_x = 0; m_c = 0;
    m_pc1 = 0; m_pc2 = 0; m_i1 = 0; m_i2 = 0; m_pred = 0;
  endtask

  task automatic model_step();
    logic req;
    req = m_req();
    m_valid = 1'b0;
    if (bus.flush) begin
      m_drop = ((m_busy || m_drop) && !bus.inst_data_ok) || (req && bus.inst_addr_ok);
      m_busy = 0; m_held = 0; m_halt = 0;
      m_pc = bus.redirect_pc;
    end else if (m_drop) begin
      if (bus.inst_data_ok) m_drop = 0;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_held) begin
      if (!bus.buffer_stall) begin
        m_push(m_h1, m_h2, m_next, 0);
        m_pc = m_next; m_held = 0;
      end
    end else if (m_busy) begin
      if (bus.inst_data_ok) begin
        m_busy = 0;
        if (!bus.buffer_stall) begin
          m_push(bus.inst_rdata1, bus.inst_rdata2, m_next, 0);
          m_pc = m_next;
        end else begin
          m_held = 1; m_h1 = bus.inst_rdata1; m_h2 = bus.inst_rdata2;
        end
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (!bus.buffer_stall) begin
        m_push(32'h03400000, 32'h03400000, m_pc + 32'd8, 1);
        m_halt = 1;
      end
    end else if (bus.inst_addr_ok) begin
      m_busy = 1;
      m_next = bus.bpu_taken ? bus.bpu_target : m_pc + 32'd8;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    chk("inst_req",  {31'b0, bus.inst_req}, {31'b0, m_req()});
    chk("inst_addr", bus.inst_addr, m_pc);
    chk("pc1",       bus.pc1, m_pc1);
    chk("pc2",       bus.pc2, m_pc2);
    chk("inst1",     bus.inst1, m_i1);
    chk("inst2",     bus.inst2, m_i2);
    chk("pred_addr", bus.pred_addr, m_pred);
    chk("exc1",      {31'b0, bus.pc_is_exception_out1}, {31'b0, m_x});
    chk("exc2",      {31'b0, bus.pc_is_exception_out2}, {31'b0, m_x});
    chk("cause1",    {25'b0, bus.pc_exception_cause_out1}, {25'b0, m_c});
    chk("cause2",    {25'b0, bus.pc_exception_cause_out2}, {25'b0, m_c});
    #2;
    chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_valid & ~bus.flush});
  end

  task automatic drive(input logic aok, input logic dok, input logic stall, input logic fl,
                       input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.buffer_stall = stall;
    bus.flush = fl; bus.redirect_pc = rpc; bus.bpu_taken = tk; bus.bpu_target = tgt;
    bus.inst_rdata1 = r1; bus.inst_rdata2 = r2;
  endtask

  task automatic cyc(input logic aok, input logic dok, input logic stall, input logic fl,
                     input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk); #1;
    drive(aok, dok, stall, fl, rpc, tk, tgt, r1, r2);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic        env_out, prev_aok, prev_dok, aok, dok, fl, tk;
  logic [31:0] rpc, tgt;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_addr", bus.inst_addr, 32'h1c000000);
    chk("rst_req", {31'b0, bus.inst_req}, 32'd1);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);

    // basic fetch
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222);
    idle(); #1;
    chk("basic_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("basic_pc1", bus.pc1, 32'h1c000000);
    chk("basic_pc2", bus.pc2, 32'h1c000004);
    chk("basic_inst1", bus.inst1, 32'h11111111);
    chk("basic_pred", bus.pred_addr, 32'h1c000008);
    chk("basic_next", bus.inst_addr, 32'h1c000008);

    // predicted taken
    cyc(1, 0, 0, 0, 0, 1, 32'h1c000100, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h33333333, 32'h44444444);
    idle(); #1;
    chk("taken_pred", bus.pred_addr, 32'h1c000100);
    chk("taken_next", bus.inst_addr, 32'h1c000100);

    // back-pressure
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 32'haaaaaaaa, 32'hbbbbbbbb); #1;
    chk("bp_valid0", {31'b0, bus.inst_valid}, 32'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    chk("bp_valid1", {31'b0, bus.inst_valid}, 32'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    chk("bp_valid2", {31'b0, bus.inst_valid}, 32'd0);
    idle(); #1;
    chk("bp_valid3", {31'b0, bus.inst_valid}, 32'd0);
    idle(); #1;
    chk("bp_pulse", {31'b0, bus.inst_valid}, 32'd1);
    chk("bp_inst1", bus.inst1, 32'haaaaaaaa);
    chk("bp_pc1", bus.pc1, 32'h1c000100);
    idle(); #1;
    chk("bp_single", {31'b0, bus.inst_valid}, 32'd0);

    // flush while waiting
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h1c000200, 0, 0, 0, 0);
    idle(); #1;
    chk("fw_req0", {31'b0, bus.inst_req}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hdeadbeef, 32'hdeadbeef); #1;
    chk("fw_req1", {31'b0, bus.inst_req}, 32'd0);
    idle(); #1;
    chk("fw_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("fw_req2", {31'b0, bus.inst_req}, 32'd1);
    chk("fw_addr", bus.inst_addr, 32'h1c000200);

    // misaligned redirect
    cyc(0, 0, 0, 1, 32'h1c000302, 0, 0, 0, 0);
    idle(); #1;
    chk("ma_req", {31'b0, bus.inst_req}, 32'd0);
    idle(); #1;
    chk("ma_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("ma_pc1", bus.pc1, 32'h1c000302);
    chk("ma_pc2", bus.pc2, 32'h1c000306);
    chk("ma_inst1", bus.inst1, 32'h03400000);
    chk("ma_inst2", bus.inst2, 32'h03400000);
    chk("ma_exc1", {31'b0, bus.pc_is_exception_out1}, 32'd1);
    chk("ma_exc2", {31'b0, bus.pc_is_exception_out2}, 32'd1);
    chk("ma_cause1", {25'b0, bus.pc_exception_cause_out1}, 32'h08);
    chk("ma_cause2", {25'b0, bus.pc_exception_cause_out2}, 32'h08);
    for (int i = 0; i < 3; i++) begin
      idle(); #1;
      chk("halt_req", {31'b0, bus.inst_req}, 32'd0);
      chk("halt_valid", {31'b0, bus.inst_valid}, 32'd0);
    end

    // flush colliding with a pending push
    cyc(0, 0, 0, 1, 32'h1c000400, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h55555555, 32'h66666666);
    cyc(0, 0, 0, 1, 32'h1c000500, 0, 0, 0, 0); #1;
    chk("coll_valid", {31'b0, bus.inst_valid}, 32'd0);
    idle(); #1;
    chk("coll_addr", bus.inst_addr, 32'h1c000500);
    chk("coll_valid2", {31'b0, bus.inst_valid}, 32'd0);

    // reset mid-transaction
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; #1;
    chk("mrst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("mrst_pc1", bus.pc1, 32'h0);
    chk("mrst_pred", bus.pred_addr, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1; #1;
    chk("mrst_addr", bus.inst_addr, 32'h1c000000);

    // random traffic against a legal one-outstanding cache
    env_out = 0; prev_aok = 0; prev_dok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (prev_dok) env_out = 0;
      if (prev_aok) env_out = 1;
      if ($urandom_range(0, 599) == 0) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        env_out = 0; prev_aok = 0; prev_dok = 0;
        continue;
      end
      aok = bus.inst_req && ($urandom_range(0, 2) == 0);
      dok = env_out && ($urandom_range(0, 1) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 15))
        0:       rpc = 32'h1c000000 | {$urandom_range(0, 4095), 2'b00} | 32'($urandom_range(1, 3));
        1:       rpc = 32'hfffffff8;
        default: rpc = 32'h1c000000 | {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
      endcase
      tk  = ($urandom_range(0, 3) == 0);
      tgt = $urandom() & 32'hfffffffc;
      if ($urandom_range(0, 15) == 0) tgt = tgt | 32'h2;
      if ($urandom_range(0, 15) == 0) tgt = 32'hfffffff8;
      drive(aok, dok, ($urandom_range(0, 2) == 0), fl, rpc, tk, tgt, $urandom(), $urandom());
      prev_aok = aok; prev_dok = dok;
    end

    idle(); idle();
    @(negedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
